// File: rtl/i2s_clkgen_tdm.sv
// I2S/TDM bit-clock and frame-clock generator running in the MCLK domain.
// Produces SCLK, LRCLK/FSYNC and single-cycle strobes plus slot/bit indices.
module i2s_clkgen_tdm #(
    parameter int MCLK_PER_SCLK = 4,
    parameter int SLOT_BITS     = 32,
    parameter int SLOTS         = 2,
    localparam int SW = ($clog2(SLOTS) > 1) ? $clog2(SLOTS) : 1,
    localparam int BW = ($clog2(SLOT_BITS) > 1) ? $clog2(SLOT_BITS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [1:0]    mode_i,
    output logic          sclk_o,
    output logic          lrclk_o,
    output logic          bit_strobe_o,
    output logic          sample_strobe_o,
    output logic          frame_start_o,
    output logic [SW-1:0] slot_idx_o,
    output logic [BW-1:0] bit_idx_o,
    output logic          active_o
);

    localparam int H  = MCLK_PER_SCLK / 2;
    localparam int F  = SLOTS * SLOT_BITS;
    localparam int PW = ($clog2(MCLK_PER_SCLK) > 1) ? $clog2(MCLK_PER_SCLK) : 1;
    localparam int GW = $clog2(F) + 1;

    if (MCLK_PER_SCLK < 2 || (MCLK_PER_SCLK % 2) != 0 || SLOT_BITS < 2 ||
        SLOTS < 2 || (SLOTS % 2) != 0) begin : gBadParams
        $error("i2s_clkgen_tdm: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [1:0]      mode_q, mode_d;

    logic            sclk_q, sclk_d;
    logic            lrclk_q, lrclk_d;
    logic            bitStrobe_q, bitStrobe_d;
    logic            sampleStrobe_q, sampleStrobe_d;
    logic            frameStart_q, frameStart_d;
    logic            active_q, active_d;

    logic            lastPhase, lastBit, lastSlot, frameEnd, startFrame;
    logic [GW-1:0]   g_d;

    assign lastPhase = (phase_q == PW'(MCLK_PER_SCLK - 1));
    assign lastBit   = (bit_q == BW'(SLOT_BITS - 1));
    assign lastSlot  = (slot_q == SW'(SLOTS - 1));
    assign frameEnd  = lastPhase && lastBit && lastSlot;

    // RUN and STOP only differ in whether the frame boundary restarts or idles.
    always_comb begin
        state_d    = state_q;
        startFrame = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d    = RUN;
                    startFrame = 1'b1;
                end
            end
            RUN, STOP: begin
                if (frameEnd) begin
                    if (en_i) begin
                        state_d    = RUN;
                        startFrame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = en_i ? RUN : STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        phase_d = '0;
        bit_d   = '0;
        slot_d  = '0;
        mode_d  = startFrame ? mode_i : mode_q;
        if (state_q != IDLE && !frameEnd) begin
            phase_d = lastPhase ? '0 : phase_q + PW'(1);
            bit_d   = bit_q;
            slot_d  = slot_q;
            if (lastPhase) begin
                bit_d = lastBit ? '0 : bit_q + BW'(1);
                if (lastBit) begin
                    slot_d = slot_q + SW'(1);
                end
            end
        end
    end

    assign g_d = GW'(slot_d) * GW'(SLOT_BITS) + GW'(bit_d);

    // Outputs are decoded from the next counter values so they register in step.
    always_comb begin
        active_d       = (state_d != IDLE);
        sclk_d         = active_d && (phase_d >= PW'(H));
        bitStrobe_d    = active_d && (phase_d == '0);
        sampleStrobe_d = active_d && (phase_d == PW'(H));
        frameStart_d   = bitStrobe_d && (g_d == '0);
        case (mode_d)
            2'd1:    lrclk_d = (g_d < GW'(F / 2));
            2'd2:    lrclk_d = (g_d == GW'(F - 1));
            default: lrclk_d = (g_d >= GW'(F / 2 - 1)) && (g_d <= GW'(F - 2));
        endcase
        lrclk_d = lrclk_d && active_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            bit_q          <= '0;
            slot_q         <= '0;
            mode_q         <= '0;
            sclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            bitStrobe_q    <= 1'b0;
            sampleStrobe_q <= 1'b0;
            frameStart_q   <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            slot_q         <= slot_d;
            mode_q         <= mode_d;
            sclk_q         <= sclk_d;
            lrclk_q        <= lrclk_d;
            bitStrobe_q    <= bitStrobe_d;
            sampleStrobe_q <= sampleStrobe_d;
            frameStart_q   <= frameStart_d;
            active_q       <= active_d;
        end
    end

    assign sclk_o          = sclk_q;
    assign lrclk_o         = lrclk_q;
    assign bit_strobe_o    = bitStrobe_q;
    assign sample_strobe_o = sampleStrobe_q;
    assign frame_start_o   = frameStart_q;
    assign slot_idx_o      = slot_q;
    assign bit_idx_o       = bit_q;
    assign active_o        = active_q;

endmodule

// File: tb/tb_i2s_clkgen_tdm.sv
// Directed bench for i2s_clkgen_tdm: a default-parameter instance (A) and a
// 2/16/8 TDM instance (B), checked cycle by cycle against the frame format.
module tb_i2s_clkgen_tdm;

    localparam int ACT_MODE1 = 1;
    localparam int ACT_EN0   = 2;
    localparam int ACT_EN1   = 3;
    localparam int ACT_RST   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enA, enB;
    logic [1:0] modeA, modeB;

    logic       sclkA, lrclkA, bsA, ssA, fsA, activeA;
    logic [0:0] slotA;
    logic [4:0] bitA;
    logic       sclkB, lrclkB, bsB, ssB, fsB, activeB;
    logic [2:0] slotB;
    logic [3:0] bitB;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_clkgen_tdm dutA (
        .clk_i(clk), .rst_i(rst), .en_i(enA), .mode_i(modeA),
        .sclk_o(sclkA), .lrclk_o(lrclkA), .bit_strobe_o(bsA),
        .sample_strobe_o(ssA), .frame_start_o(fsA), .slot_idx_o(slotA),
        .bit_idx_o(bitA), .active_o(activeA)
    );

    i2s_clkgen_tdm #(.MCLK_PER_SCLK(2), .SLOT_BITS(16), .SLOTS(8)) dutB (
        .clk_i(clk), .rst_i(rst), .en_i(enB), .mode_i(modeB),
        .sclk_o(sclkB), .lrclk_o(lrclkB), .bit_strobe_o(bsB),
        .sample_strobe_o(ssB), .frame_start_o(fsB), .slot_idx_o(slotB),
        .bit_idx_o(bitB), .active_o(activeB)
    );

    // Packed view: {active, sclk, lrclk, bit_strobe, sample_strobe, frame_start, slot, bit}
    function automatic logic [31:0] packOut(input int sel);
        if (sel == 0)
            return {10'd0, activeA, sclkA, lrclkA, bsA, ssA, fsA, 8'(slotA), 8'(bitA)};
        return {10'd0, activeB, sclkB, lrclkB, bsB, ssB, fsB, 8'(slotB), 8'(bitB)};
    endfunction

    // Expected outputs at MCLK cycle t of a running frame.
    function automatic logic [31:0] expectVec(input int m, input int sb, input int sl,
                                              input int md, input int t);
        int f, ph, g, h;
        logic lr;
        logic [31:0] v;
        f  = sb * sl;
        ph = t % m;
        g  = t / m;
        h  = m / 2;
        case (md)
            1:       lr = (g < f / 2);
            2:       lr = (g == f - 1);
            default: lr = (g >= f / 2 - 1) && (g <= f - 2);
        endcase
        v        = '0;
        v[21]    = 1'b1;
        v[20]    = (ph >= h);
        v[19]    = lr;
        v[18]    = (ph == 0);
        v[17]    = (ph == h);
        v[16]    = (t == 0);
        v[15:8]  = 8'(g / sb);
        v[7:0]   = 8'(g % sb);
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input int act);
        case (act)
            ACT_MODE1: if (sel == 0) modeA = 2'd1; else modeB = 2'd1;
            ACT_EN0:   if (sel == 0) enA = 1'b0; else enB = 1'b0;
            ACT_EN1:   if (sel == 0) enA = 1'b1; else enB = 1'b1;
            ACT_RST:   rst = 1'b1;
            default:   ;
        endcase
    endtask

    // Entered at the negedge of frame cycle 0; leaves at the negedge after the
    // frame, or right after asserting reset when that action fires.
    task automatic runFrame(input int sel, input int md, input int t1, input int a1,
                            input int t2, input int a2);
        int m, sb, sl;
        m  = (sel == 0) ? 4 : 2;
        sb = (sel == 0) ? 32 : 16;
        sl = (sel == 0) ? 2 : 8;
        for (int t = 0; t < m * sb * sl; t++) begin
            checkOutput($sformatf("%s md%0d t%0d", (sel == 0) ? "A" : "B", md, t),
                        packOut(sel), expectVec(m, sb, sl, md, t));
            if (t == t1) applyStimulus(sel, a1);
            if (t == t2) applyStimulus(sel, a2);
            if ((t == t1 && a1 == ACT_RST) || (t == t2 && a2 == ACT_RST)) return;
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        enA   = 1'b1;
        enB   = 1'b0;
        modeA = 2'd0;
        modeB = 2'd2;
        repeat (3) @(negedge clk);
        checkOutput("resetIdleA", packOut(0), 32'd0);
        checkOutput("resetIdleB", packOut(1), 32'd0);

        // First non-reset edge samples en=1, so the next cycle is frame_start.
        rst = 1'b0;
        @(negedge clk);
        runFrame(0, 0, -1, 0, -1, 0);
        runFrame(0, 0, 40, ACT_MODE1, -1, 0);
        runFrame(0, 1, 20, ACT_EN0, -1, 0);

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stopIdleA%0d", i), packOut(0), 32'd0);
            @(negedge clk);
        end
        applyStimulus(0, ACT_EN1);
        @(negedge clk);
        runFrame(0, 1, 20, ACT_EN0, 80, ACT_EN1);
        runFrame(0, 1, 20, ACT_EN0, 255, ACT_EN1);
        runFrame(0, 1, 160, ACT_RST, -1, 0);

        @(negedge clk);
        checkOutput("midFrameResetA", packOut(0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        runFrame(0, 1, 10, ACT_EN0, -1, 0);
        checkOutput("finalIdleA", packOut(0), 32'd0);

        applyStimulus(1, ACT_EN1);
        @(negedge clk);
        runFrame(1, 2, -1, 0, -1, 0);
        runFrame(1, 2, 0, ACT_EN0, -1, 0);
        checkOutput("finalIdleB", packOut(1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_clkgen_tdm.md
# i2s_clkgen_tdm

Parametrised I2S/TDM bit-clock and frame-clock generator, run from the MCLK domain. It divides MCLK into SCLK and a frame clock (LRCLK/FSYNC) for any slot width and slot count. The frame format (I2S, left-justified or DSP/TDM) is selectable at runtime, and the generator can be started and stopped cleanly with an enable. It sits in front of the I2S serializers and deserializers and supplies them with single-cycle bit, sample and frame strobes plus the current slot and bit index, so they need no counters of their own.

## Interface
- MCLK_PER_SCLK, 4: MCLK cycles per SCLK period; even, ≥2.
- SLOT_BITS, 32: SCLK periods per slot; ≥2.
- SLOTS, 2: slots per frame; even, ≥2. Frame length F = SLOTS*SLOT_BITS bit periods. Defaults give 256 MCLK per frame (48 kHz at 12.288 MHz).
- Illegal parameter values fail elaboration.
- clk  in  1  MCLK; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request.
- mode  in  2  frame format: 0 = I2S, 1 = left-justified, 2 = DSP/TDM, 3 = reserved (behaves as 0).
- sclk  out  1  bit clock.
- lrclk  out  1  word select (I2S/LJ) or frame-sync pulse (DSP).
- bit_strobe  out  1  first clk cycle of each bit period (sclk falling); transmitters update data here.
- sample_strobe  out  1  first clk cycle with sclk high; receivers sample here.
- frame_start  out  1  coincides with bit_strobe of bit period g=0.
- slot_idx  out  max(1,$clog2(SLOTS))  slot of the current bit period.
- bit_idx  out  max(1,$clog2(SLOT_BITS))  bit within slot; 0 = MSB.
- active  out  1  high while frames are being generated.

## Operation
- Counters:
  - phase counts 0..MCLK_PER_SCLK-1 within a bit period.
  - bit counts 0..SLOT_BITS-1 and slot counts 0..SLOTS-1, giving global bit index g = slot*SLOT_BITS + bit.
  - All counters wrap to 0 together at the end of a frame.
- Let H = MCLK_PER_SCLK/2. sclk is 0 for phase < H and 1 for phase ≥ H.
- bit_strobe is high at phase 0; sample_strobe is high at phase H.
- slot_idx/bit_idx give the slot and bit the serializer presents during bit period g, in every mode. The mode only changes lrclk.
- lrclk per mode:
  - I2S: 0 for g = F-1 and for g < F/2-1; 1 for F/2-1 ≤ g ≤ F-2. LRCLK leads the MSB by one SCLK; low = left half.
  - LJ: 1 for g < F/2, 0 otherwise.
  - DSP: 1 only for g = F-1, a one-SCLK pulse ahead of the slot-0 MSB.
- States:
  - IDLE → RUN when en=1.
  - RUN → STOP when en=0 is sampled.
  - STOP → IDLE at the last cycle of the frame (g=F-1, phase=MCLK_PER_SCLK-1).
  - STOP → RUN if en returns to 1 before the frame ends; the frame continues seamlessly.
- Frames are never truncated by en.
- mode is sampled on the edge that begins each frame and held for that whole frame. Changes mid-frame have no effect until the next frame_start.
- Idle and reset output values: sclk=0, lrclk=0, all strobes=0, slot_idx=0, bit_idx=0, active=0, counters=0.

## Timing
- All outputs are registered.
- If en=1 is sampled at edge k while IDLE, the cycle after edge k is phase 0 of g=0: frame_start=1, bit_strobe=1, active=1, sclk=0.
- frame_start repeats exactly every F*MCLK_PER_SCLK cycles while running.
- In the cycle after the final cycle of the last frame, every output is at its idle value.
- If en is high again on that boundary edge, the next frame starts back-to-back with no idle cycle.
- rst=1 at an edge forces idle values in the next cycle regardless of state, with no partial-frame completion. rst has priority over en.
- After rst deasserts, en is re-sampled at the first non-reset edge.
- With MCLK_PER_SCLK=2, bit_strobe and sample_strobe fall on alternate cycles.

## Test plan
- Defaults, mode 0, en=1 held:
  - frame_start every 256 cycles; sclk period 4 with 2 cycles high.
  - lrclk=0 for g 0..30 and g 63, 1 for g 31..62.
  - bit_idx counts 0..31 twice per frame; slot_idx goes 0 then 1.
- Defaults, mode 1: lrclk=1 for g 0..31 and 0 for g 32..63; sample_strobe is at phase 2 of every bit period.
- MCLK_PER_SCLK=2, SLOT_BITS=16, SLOTS=8, mode 2:
  - frame is 256 cycles; lrclk is high only for g=127 (2 cycles), immediately before frame_start.
  - slot_idx steps 0..7, each for 32 cycles.
- Mode switched from 0 to 1 at g=10: lrclk follows the I2S pattern until the frame ends, then the LJ pattern from the next frame_start.
- en dropped at g=5:
  - frame runs to g=63; the following cycle active=0 and sclk=lrclk=0.
  - en=1 again → frame_start exactly one cycle after en is sampled.
- rst pulsed for 1 cycle at g=40: next cycle shows all idle values; with en still 1, frame_start occurs in the cycle after the first non-reset edge.
